// File: rtl/npu_result_buffer_pkg.sv
// rtl/npu_result_buffer_pkg.sv - drain state type and saturating lane add for the result buffer
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_e;

  // Operands arrive sign-extended from DATA_W bits, so the 32-bit sum cannot overflow.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int DATA_W);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/npu_result_buffer_if.sv
// rtl/npu_result_buffer_if.sv - PE write port and drain stream bundle for the result buffer
interface npu_result_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = LANES * DATA_W;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [LANES-1:0]   wr_lane_mask;
  logic               acc_en;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic [ADDR_W-1:0]  out_addr;

  modport master (
    output wr_en, wr_addr, wr_data, wr_lane_mask, acc_en, out_ready,
    input  out_valid, out_data, out_addr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_lane_mask, acc_en, out_ready,
    output out_valid, out_data, out_addr
  );
endinterface

// File: rtl/npu_result_buffer_drain.sv
// rtl/npu_result_buffer_drain.sv - drain FSM, length clamp, address counter and output register
module npu_res_buf_drain
  import npu_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int ENTRY_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W:0]    drain_len,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               start_accept,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [ADDR_W-1:0]  out_addr
);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  drain_state_e    state, state_n;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] issue_cnt;
  logic [ADDR_W:0] len_clamped;
  logic            issue;

  assign len_clamped = (drain_len > MAX_LEN) ? MAX_LEN : drain_len;
  assign rd_addr     = issue_cnt[ADDR_W-1:0];
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A new read is issued whenever the output slot is empty or being emptied this cycle,
  // which keeps one entry per cycle flowing while out_ready stays high.
  always_comb begin
    state_n      = state;
    issue        = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_n      = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issue = (issue_cnt != len_q) && (!out_valid || out_ready);
        if (out_valid && out_ready && (issue_cnt == len_q)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      issue_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      if (start_accept) begin
        len_q     <= len_clamped;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (issue) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_addr  <= rd_addr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/npu_result_buffer.sv
// rtl/npu_result_buffer.sv - multi-lane result storage with masked write and drain stream
// Optional in-place saturating accumulate is built when RES_BUF_ACCUM_EN is defined.
module npu_result_buffer
  import npu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  npu_result_buffer_if.slave    bus,
  input  logic                  start,
  input  logic [$clog2(DEPTH):0] drain_len,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = LANES * DATA_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_word;
  logic [ADDR_W-1:0]  rd_addr;
  logic               start_accept;

  // Merge the write into the current entry so unmasked lanes keep their value.
  always_comb begin
    wr_word = mem[bus.wr_addr];
    for (int l = 0; l < LANES; l++) begin
      if (bus.wr_lane_mask[l]) begin
`ifdef RES_BUF_ACCUM_EN
        if (bus.acc_en)
          wr_word[l*DATA_W +: DATA_W] = DATA_W'(sat_add(
              32'(signed'(mem[bus.wr_addr][l*DATA_W +: DATA_W])),
              32'(signed'(bus.wr_data[l*DATA_W +: DATA_W])), DATA_W));
        else
          wr_word[l*DATA_W +: DATA_W] = bus.wr_data[l*DATA_W +: DATA_W];
`else
        wr_word[l*DATA_W +: DATA_W] = bus.wr_data[l*DATA_W +: DATA_W];
`endif
      end
    end
  end

`ifndef RES_BUF_ACCUM_EN
  logic unused_acc_en;
  assign unused_acc_en = bus.acc_en;
`endif

  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy) mem[bus.wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wr_err <= 1'b0;
    else if (start_accept)       wr_err <= 1'b0;
    else if (bus.wr_en && busy)  wr_err <= 1'b1;
  end

  npu_res_buf_drain #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ENTRY_W (ENTRY_W)
  ) u_drain (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .drain_len    (drain_len),
    .rd_data      (mem[rd_addr]),
    .rd_addr      (rd_addr),
    .start_accept (start_accept),
    .busy         (busy),
    .done         (done),
    .out_valid    (bus.out_valid),
    .out_ready    (bus.out_ready),
    .out_data     (bus.out_data),
    .out_addr     (bus.out_addr)
  );

endmodule
